am_demod: RTL and testbench

- Receive-side counterpart to the AM modulator: consumes the signed 16-bit AM sample stream (AM_mod format) and recovers the 8-bit unsigned message (cos_100k format).
- Method: full-wave rectification, boxcar moving-average low-pass over 2^AVG_LOG2 samples, scale/saturate, optional decimation.
- Sits after the modulator in loopback and self-test builds, or behind an ADC front end.

---
 rtl/am_demod.sv | 212 +++++++++++++++++++++
 tb/tb_am_demod.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/am_demod.sv
// am_demod: AM envelope detector built from a rectifier, a 2^AVG_LOG2 boxcar average, scale/saturate and a decimated strobe.
// Defining AM_DEMOD_DC_BLOCK_EN adds a DC-blocking leaky integrator (offset-binary output, one extra cycle of latency).
module am_demod #(
    parameter int AVG_LOG2  = 5,
    parameter int OUT_SHIFT = 7,
    parameter int DECIM     = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [15:0] AM_mod,
    input  logic               in_valid,
    output logic [7:0]         demod,
    output logic               demod_valid
);
    localparam int N  = 1 << AVG_LOG2;
    localparam int SW = 15 + AVG_LOG2;
    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [AVG_LOG2-1:0] FILL_LAST = {AVG_LOG2{1'b1}};
    localparam logic [DW-1:0]       DEC_LAST  = DW'(DECIM - 1);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // -32768 has no positive 16-bit counterpart and saturates to 32767
    function automatic logic [14:0] rectify(input logic signed [15:0] x);
        logic [15:0] mag;
        mag = x[15] ? (16'd0 - $unsigned(x)) : $unsigned(x);
        return mag[15] ? 15'h7FFF : mag[14:0];
    endfunction

    state_e              state_q;
    logic [AVG_LOG2-1:0] fill_cnt_q;
    logic [DW-1:0]       dec_cnt_q;
    logic                v1_q;
    logic                stb1_q;
    logic [14:0]         abs_q;

    // Acceptance stage: rectify the sample and tag it with its strobe decision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FILL;
            fill_cnt_q <= {AVG_LOG2{1'b0}};
            dec_cnt_q  <= {DW{1'b0}};
            v1_q       <= 1'b0;
            stb1_q     <= 1'b0;
            abs_q      <= 15'd0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                abs_q <= rectify(AM_mod);
                case (state_q)
                    ST_FILL: begin
                        if (fill_cnt_q == FILL_LAST) begin
                            state_q   <= ST_RUN;
                            stb1_q    <= 1'b1;
                            dec_cnt_q <= (dec_cnt_q == DEC_LAST) ? {DW{1'b0}} : dec_cnt_q + DW'(1);
                        end else begin
                            fill_cnt_q <= fill_cnt_q + AVG_LOG2'(1);
                            stb1_q     <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        stb1_q    <= (dec_cnt_q == {DW{1'b0}});
                        dec_cnt_q <= (dec_cnt_q == DEC_LAST) ? {DW{1'b0}} : dec_cnt_q + DW'(1);
                    end
                    default: begin
                        state_q <= ST_FILL;
                        stb1_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    logic [14:0]         dline_q [N];
    logic [AVG_LOG2-1:0] wptr_q;
    logic [SW-1:0]       sum_q;
    logic                v2_q;
    logic                stb2_q;

    // Boxcar stage: overwrite the oldest entry and adjust the running sum (zeroed line keeps fill exact)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                dline_q[i] <= 15'd0;
            end
            wptr_q <= {AVG_LOG2{1'b0}};
            sum_q  <= {SW{1'b0}};
            v2_q   <= 1'b0;
            stb2_q <= 1'b0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                dline_q[wptr_q] <= abs_q;
                wptr_q          <= wptr_q + AVG_LOG2'(1);
                sum_q           <= sum_q + SW'(abs_q) - SW'(dline_q[wptr_q]);
                stb2_q          <= stb1_q;
            end
        end
    end

    logic [SW-1:0] scaled_s;
    logic [7:0]    val_s;

    // Average, scale to 8 bits and saturate
    always_comb begin
        scaled_s = (sum_q >> AVG_LOG2) >> OUT_SHIFT;
        val_s    = (scaled_s > SW'(255)) ? 8'hFF : scaled_s[7:0];
    end

    logic       v3_q;
    logic       stb3_q;
    logic [7:0] val_q;

    // Scaled level register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_q   <= 1'b0;
            stb3_q <= 1'b0;
            val_q  <= 8'd0;
        end else begin
            v3_q <= v2_q;
            if (v2_q) begin
                val_q  <= val_s;
                stb3_q <= stb2_q;
            end
        end
    end

    logic       out_v_s;
    logic       out_stb_s;
    logic [7:0] out_val_s;

`ifdef AM_DEMOD_DC_BLOCK_EN
    logic signed [15:0] dc_q;
    logic               run_seen_q;
    logic               v4_q;
    logic               stb4_q;
    logic [7:0]         corr_q;
    logic signed [16:0] dc_err_s;
    logic signed [15:0] dc_step_s;
    logic signed [15:0] dc_int_s;
    logic signed [17:0] corr_s;
    logic [7:0]         corr_val_s;

    // dc holds 6 fractional bits; correction recentres the level on 128
    always_comb begin
        dc_err_s  = $signed({3'b000, val_q, 6'b000000}) - $signed({dc_q[15], dc_q});
        dc_step_s = 16'(dc_err_s >>> 6);
        dc_int_s  = dc_q >>> 6;
        corr_s    = $signed({10'b0000000000, val_q}) - $signed({{2{dc_int_s[15]}}, dc_int_s}) + 18'sd128;
        if (corr_s < 18'sd0) begin
            corr_val_s = 8'd0;
        end else if (corr_s > 18'sd255) begin
            corr_val_s = 8'd255;
        end else begin
            corr_val_s = corr_s[7:0];
        end
    end

    // Leaky integrator only tracks samples from the first strobe onward
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dc_q       <= 16'sd0;
            run_seen_q <= 1'b0;
            v4_q       <= 1'b0;
            stb4_q     <= 1'b0;
            corr_q     <= 8'd0;
        end else begin
            v4_q <= v3_q;
            if (v3_q) begin
                corr_q <= corr_val_s;
                stb4_q <= stb3_q;
                if (stb3_q || run_seen_q) begin
                    dc_q       <= dc_q + dc_step_s;
                    run_seen_q <= 1'b1;
                end
            end
        end
    end

    assign out_v_s   = v4_q;
    assign out_stb_s = stb4_q;
    assign out_val_s = corr_q;
`else
    assign out_v_s   = v3_q;
    assign out_stb_s = stb3_q;
    assign out_val_s = val_q;
`endif

    logic [7:0] demod_q;
    logic       demod_valid_q;

    // Output register: value follows every accepted sample, strobe only for tagged ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            demod_q       <= 8'd0;
            demod_valid_q <= 1'b0;
        end else begin
            demod_valid_q <= out_v_s & out_stb_s;
            if (out_v_s) begin
                demod_q <= out_val_s;
            end
        end
    end

    assign demod       = demod_q;
    assign demod_valid = demod_valid_q;

endmodule

// File: tb/tb_am_demod.sv
`timescale 1ns/1ps
// Bench for am_demod: four parameterisations share one stimulus stream and are compared against
// a reference computed from the history of accepted samples.
module tb_am_demod;
    localparam int NI = 4;
`ifdef AM_DEMOD_DC_BLOCK_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    function automatic int p_l(input int i); return (i == 3) ? 3 : 5; endfunction
    function automatic int p_s(input int i); return (i == 1) ? 6 : 7; endfunction
    function automatic int p_d(input int i); return (i == 2) ? 4 : 1; endfunction

    logic               clk      = 1'b0;
    logic               rst_n    = 1'b0;
    logic signed [15:0] AM_mod   = 16'sd0;
    logic               in_valid = 1'b0;
    logic [7:0]         dem_a, dem_b, dem_c, dem_d;
    logic               dv_a, dv_b, dv_c, dv_d;
    logic [7:0]         dem [NI];
    logic               dv  [NI];

    assign dem[0] = dem_a; assign dem[1] = dem_b; assign dem[2] = dem_c; assign dem[3] = dem_d;
    assign dv[0]  = dv_a;  assign dv[1]  = dv_b;  assign dv[2]  = dv_c;  assign dv[3]  = dv_d;

    always #5 clk = ~clk;

    am_demod #(.AVG_LOG2(5), .OUT_SHIFT(7), .DECIM(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .AM_mod(AM_mod), .in_valid(in_valid), .demod(dem_a), .demod_valid(dv_a));
    am_demod #(.AVG_LOG2(5), .OUT_SHIFT(6), .DECIM(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .AM_mod(AM_mod), .in_valid(in_valid), .demod(dem_b), .demod_valid(dv_b));
    am_demod #(.AVG_LOG2(5), .OUT_SHIFT(7), .DECIM(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .AM_mod(AM_mod), .in_valid(in_valid), .demod(dem_c), .demod_valid(dv_c));
    am_demod #(.AVG_LOG2(3), .OUT_SHIFT(7), .DECIM(1)) dut_d (
        .clk(clk), .rst_n(rst_n), .AM_mod(AM_mod), .in_valid(in_valid), .demod(dem_d), .demod_valid(dv_d));

    int abs_hist[$];
    int acc_cnt;
    int dc_m [NI];
    int ed   [NI][LAT+1];
    bit ev   [NI][LAT+1];
    int checks = 0;
    int errors = 0;

    // Level for instance i: mean of the last N rectified samples, scaled and saturated
    function automatic int ref_val(input int i);
        longint s;
        int     n;
        s = 0;
        n = 1 << p_l(i);
        for (int j = 0; j < n && j < abs_hist.size(); j++) s += abs_hist[abs_hist.size() - 1 - j];
        s = s >>> (p_l(i) + p_s(i));
        return (s > 255) ? 255 : int'(s);
    endfunction

    task automatic model_clear();
        abs_hist.delete();
        acc_cnt = 0;
        for (int i = 0; i < NI; i++) begin
            dc_m[i] = 0;
            for (int j = 0; j <= LAT; j++) begin ed[i][j] = 0; ev[i][j] = 1'b0; end
        end
    endtask

    // One clock: drive inputs, advance the reference; ed/ev[LAT] is what the outputs must show now
    task automatic step(input int x, input bit v);
        int a, val, n, outv;
        AM_mod   = 16'(x);
        in_valid = v;
        @(posedge clk);
        for (int i = 0; i < NI; i++)
            for (int j = LAT; j > 0; j--) begin ed[i][j] = ed[i][j-1]; ev[i][j] = ev[i][j-1]; end
        if (v) begin
            a = (x < 0) ? -x : x;
            if (a > 32767) a = 32767;
            abs_hist.push_back(a);
            if (abs_hist.size() > 256) void'(abs_hist.pop_front());
            acc_cnt++;
            for (int i = 0; i < NI; i++) begin
                n        = 1 << p_l(i);
                val      = ref_val(i);
                ev[i][0] = (acc_cnt >= n) && (((acc_cnt - n) % p_d(i)) == 0);
`ifdef AM_DEMOD_DC_BLOCK_EN
                outv = val - (dc_m[i] >>> 6) + 128;
                outv = (outv < 0) ? 0 : ((outv > 255) ? 255 : outv);
                if (acc_cnt >= n) dc_m[i] = dc_m[i] + ((val * 64 - dc_m[i]) >>> 6);
`else
                outv = val;
`endif
                ed[i][0] = outv;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin ev[i][0] = 1'b0; ed[i][0] = ed[i][1]; end
        end
        #1;
    endtask

    task automatic reset_dut();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_clear();
        for (int c = 0; c < 6; c++) begin
            AM_mod   = 16'($urandom);
            in_valid = 1'b1;
            @(posedge clk); #1;
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (dem[i] !== 8'd0 || dv[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_hold inst%0d: demod=%0d valid=%0b, expected 0/0", i, dem[i], dv[i]);
                end
            end
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        for (int s = 0; s < 20; s++) begin
            step(int'($urandom_range(0, 65535)) - 32768, 1'b1);
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (dem[i] !== 8'(ed[i][LAT]) || dv[i] !== ev[i][LAT]) begin
                    errors++;
                    $display("FAIL reset_stream inst%0d step%0d: demod=%0d valid=%0b, expected %0d/%0b",
                             i, s, dem[i], dv[i], ed[i][LAT], ev[i][LAT]);
                end
            end
        end
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (dem[i] !== 8'd0 || dv[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_async inst%0d: demod=%0d valid=%0b, expected 0/0 before any edge", i, dem[i], dv[i]);
            end
        end
        model_clear();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_constant_pos();
        reset_dut();
        for (int s = 1; s <= 40; s++) begin
            step(12800, 1'b1);
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (dem[i] !== 8'(ed[i][LAT]) || dv[i] !== ev[i][LAT]) begin
                    errors++;
                    $display("FAIL const_pos inst%0d step%0d: demod=%0d valid=%0b, expected %0d/%0b",
                             i, s, dem[i], dv[i], ed[i][LAT], ev[i][LAT]);
                end
            end
            if (s == 31 + LAT) begin
                checks++;
                if (dv[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL const_pos_early step%0d: valid=%0b, expected 0", s, dv[0]);
                end
            end
            if (s == 32 + LAT) begin
                checks++;
                if (dv[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL const_pos_first_strobe step%0d: valid=%0b, expected 1", s, dv[0]);
                end
            end
        end
`ifndef AM_DEMOD_DC_BLOCK_EN
        checks++;
        if (dem[0] !== 8'd100) begin
            errors++;
            $display("FAIL const_pos_value: demod=%0d, expected 100", dem[0]);
        end
`endif
    endtask

    task automatic test_rectify();
        reset_dut();
        for (int s = 1; s <= 40; s++) begin
            step(-12800, 1'b1);
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (dem[i] !== 8'(ed[i][LAT]) || dv[i] !== ev[i][LAT]) begin
                    errors++;
                    $display("FAIL const_neg inst%0d step%0d: demod=%0d valid=%0b, expected %0d/%0b",
                             i, s, dem[i], dv[i], ed[i][LAT], ev[i][LAT]);
                end
            end
        end
        reset_dut();
        for (int s = 1; s <= 40; s++) begin
            step(-32768, 1'b1);
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (dem[i] !== 8'(ed[i][LAT]) || dv[i] !== ev[i][LAT]) begin
                    errors++;
                    $display("FAIL full_scale inst%0d step%0d: demod=%0d valid=%0b, expected %0d/%0b",
                             i, s, dem[i], dv[i], ed[i][LAT], ev[i][LAT]);
                end
            end
        end
`ifndef AM_DEMOD_DC_BLOCK_EN
        checks++;
        if (dem[0] !== 8'd255 || dem[1] !== 8'd255) begin
            errors++;
            $display("FAIL full_scale_sat: demod shift7=%0d shift6=%0d, expected 255/255", dem[0], dem[1]);
        end
`endif
    endtask

    task automatic test_stall();
        reset_dut();
        for (int s = 1; s <= 200; s++) begin
            step(6400, (s % 2) == 1);
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (dem[i] !== 8'(ed[i][LAT]) || dv[i] !== ev[i][LAT]) begin
                    errors++;
                    $display("FAIL stall inst%0d step%0d: demod=%0d valid=%0b, expected %0d/%0b",
                             i, s, dem[i], dv[i], ed[i][LAT], ev[i][LAT]);
                end
            end
        end
`ifndef AM_DEMOD_DC_BLOCK_EN
        checks++;
        if (dem[0] !== 8'd50) begin
            errors++;
            $display("FAIL stall_value: demod=%0d, expected 50", dem[0]);
        end
`endif
    endtask

    task automatic test_decimation();
        int strobes;
        reset_dut();
        strobes = 0;
        for (int s = 1; s <= 60 + LAT; s++) begin
            step((s <= 60) ? 12800 : int'($urandom_range(0, 65535)) - 32768, s <= 60);
            if (dv[2] === 1'b1) strobes++;
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (dem[i] !== 8'(ed[i][LAT]) || dv[i] !== ev[i][LAT]) begin
                    errors++;
                    $display("FAIL decim inst%0d step%0d: demod=%0d valid=%0b, expected %0d/%0b",
                             i, s, dem[i], dv[i], ed[i][LAT], ev[i][LAT]);
                end
            end
        end
        checks++;
        if (strobes !== 8) begin
            errors++;
            $display("FAIL decim_count: strobes=%0d, expected 8", strobes);
        end
        reset_dut();
        for (int s = 1; s <= 10; s++) step(12800, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dem[0] !== 8'd0 || dv[0] !== 1'b0) begin
            errors++;
            $display("FAIL fill_reset_async: demod=%0d valid=%0b, expected 0/0", dem[0], dv[0]);
        end
        model_clear();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int s = 1; s <= 32 + LAT; s++) begin
            step(12800, 1'b1);
            if (s == 31 + LAT || s == 32 + LAT) begin
                checks++;
                if (dv[0] !== (s == 32 + LAT)) begin
                    errors++;
                    $display("FAIL fill_reset_restart step%0d: valid=%0b, expected %0b", s, dv[0], s == 32 + LAT);
                end
            end
        end
    endtask

    task automatic test_loopback();
        int env, dir, diff;
        int env_q[$];
        reset_dut();
        env = int'($urandom_range(0, 255));
        dir = 1;
        for (int s = 0; s < 200; s++) begin
            env_q.push_back(env);
            step(((s % 2) == 1) ? -(env * 128) : env * 128, 1'b1);
            checks++;
            if (dem[3] !== 8'(ed[3][LAT]) || dv[3] !== ev[3][LAT]) begin
                errors++;
                $display("FAIL loopback step%0d: demod=%0d valid=%0b, expected %0d/%0b",
                         s, dem[3], dv[3], ed[3][LAT], ev[3][LAT]);
            end
`ifndef AM_DEMOD_DC_BLOCK_EN
            if (s >= 20) begin
                diff = int'(dem[3]) - env_q[s - LAT];
                checks++;
                if (diff > 8 || diff < -8) begin
                    errors++;
                    $display("FAIL loopback_track step%0d: demod=%0d, expected within 8 of %0d", s, dem[3], env_q[s - LAT]);
                end
            end
`endif
            if (env + dir > 255 || env + dir < 0) dir = -dir;
            env = env + dir;
        end
    endtask

    task automatic test_random();
        reset_dut();
        for (int s = 0; s < 300; s++) begin
            step(int'($urandom_range(0, 65535)) - 32768, $urandom_range(0, 3) != 0);
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (dem[i] !== 8'(ed[i][LAT]) || dv[i] !== ev[i][LAT]) begin
                    errors++;
                    $display("FAIL random inst%0d step%0d: demod=%0d valid=%0b, expected %0d/%0b",
                             i, s, dem[i], dv[i], ed[i][LAT], ev[i][LAT]);
                end
            end
        end
    endtask

`ifdef AM_DEMOD_DC_BLOCK_EN
    task automatic test_dc_block();
        reset_dut();
        for (int s = 0; s < 600; s++) begin
            step(12800, 1'b1);
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (dem[i] !== 8'(ed[i][LAT]) || dv[i] !== ev[i][LAT]) begin
                    errors++;
                    $display("FAIL dc_block inst%0d step%0d: demod=%0d valid=%0b, expected %0d/%0b",
                             i, s, dem[i], dv[i], ed[i][LAT], ev[i][LAT]);
                end
            end
        end
        checks++;
        if (dem[0] < 8'd127 || dem[0] > 8'd129) begin
            errors++;
            $display("FAIL dc_block_settle: demod=%0d, expected 127..129", dem[0]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_constant_pos();
        test_rectify();
        test_stall();
        test_decimation();
        test_loopback();
        test_random();
`ifdef AM_DEMOD_DC_BLOCK_EN
        test_dc_block();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

endmodule
